div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 129 ++++++++++++
 tb/tb_div_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// 32-bit sequential restoring divider (DIV/DIVU): result 34 edges after accept, 3 for divide-by-zero.
// Holds result_o/ready_o while start_i stays high; annul_i aborts only while iterating.
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_q, state_n;
  logic [5:0]  cnt_q, cnt_n;
  logic [31:0] rem_q, rem_n;
  logic [31:0] quo_q, quo_n;
  logic [31:0] dvs_q, dvs_n;
  logic        neg_quo_q, neg_quo_n;
  logic        neg_rem_q, neg_rem_n;
  logic [63:0] result_n;
  logic        ready_n;

  logic [31:0] mag1, mag2;
  logic [32:0] trial;

  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // quo_q starts as the dividend and shifts left, feeding the remainder while quotient bits fill in
  assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    rem_n     = rem_q;
    quo_n     = quo_q;
    dvs_n     = dvs_q;
    neg_quo_n = neg_quo_q;
    neg_rem_n = neg_rem_q;
    result_n  = result_o;
    ready_n   = ready_o;

    case (state_q)
      FREE: begin
        result_n = 64'h0;
        ready_n  = 1'b0;
        if (start_i && !annul_i) begin
          rem_n     = 32'h0;
          quo_n     = mag1;
          dvs_n     = mag2;
          cnt_n     = 6'd0;
          neg_quo_n = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_n = signed_div_i & opdata1_i[31];
          state_n   = (opdata2_i == 32'h0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        state_n  = END;
        result_n = 64'h0;
        ready_n  = 1'b0;
      end
      ON: begin
        if (annul_i) begin
          state_n  = FREE;
          cnt_n    = 6'd0;
          result_n = 64'h0;
          ready_n  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_n  = END;
          cnt_n    = 6'd0;
          ready_n  = 1'b1;
          result_n = {(neg_rem_q ? (~rem_q + 32'd1) : rem_q),
                      (neg_quo_q ? (~quo_q + 32'd1) : quo_q)};
        end else begin
          cnt_n = cnt_q + 6'd1;
          if (!trial[32]) begin
            rem_n = trial[31:0];
            quo_n = {quo_q[30:0], 1'b1};
          end else begin
            rem_n = {rem_q[30:0], quo_q[31]};
            quo_n = {quo_q[30:0], 1'b0};
          end
        end
      end
      END: begin
        ready_n = 1'b1;
        if (!start_i) begin
          state_n  = FREE;
          result_n = 64'h0;
          ready_n  = 1'b0;
        end
      end
      default: begin
        state_n  = FREE;
        result_n = 64'h0;
        ready_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FREE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'h0;
      quo_q     <= 32'h0;
      dvs_q     <= 32'h0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= 64'h0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rem_q     <= rem_n;
      quo_q     <= quo_n;
      dvs_q     <= dvs_n;
      neg_quo_q <= neg_quo_n;
      neg_rem_q <= neg_rem_n;
      result_o  <= result_n;
      ready_o   <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'h0;
  logic [31:0] opdata2_i = 32'h0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero; divide by zero yields 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit drop);
    logic [63:0] exp;
    int          lat;
    bit          early;
    exp   = ref_div(s, a, b);
    lat   = (b == 32'h0) ? 3 : 34;
    early = 1'b0;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    for (int i = 0; i < lat - 1; i++) begin
      tick();
      if (ready_o) early = 1'b1;
      if (drop && b != 32'h0) start_i = !(i >= 4 && i < 20);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
    end
    chk("early_ready", {63'h0, early}, 64'h0);
    tick();
    chk("ready", {63'h0, ready_o}, 64'h1);
    chk("result", result_o, exp);
    for (int k = 0; k < hold; k++) begin
      annul_i = 1'($urandom);
      tick();
      chk("hold_ready", {63'h0, ready_o}, 64'h1);
      chk("hold_result", result_o, exp);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk("drop_ready", {63'h0, ready_o}, 64'h0);
    chk("drop_result", result_o, 64'h0);
  endtask

  initial begin
    bit          seen;
    logic        s;
    logic [31:0] a, b;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_ready", {63'h0, ready_o}, 64'h0);
    chk("reset_result", result_o, 64'h0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    do_div(1'b0, 32'd100, 32'd7, 5, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
    do_div(1'b0, 32'd5, 32'd0, 2, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'h0000_0000, 0, 1'b0);
    do_div(1'b0, 32'd100, 32'd7, 0, 1'b1);
    do_div(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0);

    // annul at E10: operation is discarded and ready never rises
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    chk("annul_ready", {63'h0, seen}, 64'h0);
    chk("annul_result", result_o, 64'h0);
    do_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

    // reset mid-operation between E15 and E16
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'h0, ready_o}, 64'h0);
    chk("midrst_result", result_o, 64'h0);
    start_i = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);

    // reset while a result is being held
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int i = 0; i < 34; i++) tick();
    chk("endrst_pre_ready", {63'h0, ready_o}, 64'h1);
    chk("endrst_pre_result", result_o, {32'd1, 32'd333});
    #2 rst_n = 1'b0;
    #1;
    chk("endrst_ready", {63'h0, ready_o}, 64'h0);
    chk("endrst_result", result_o, 64'h0);
    start_i = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_div(s, a, b, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
